// File: rtl/hazard_pkg.sv
// Shared types and constants for the PPU hazard/pipeline-control unit.
// Scoreboard entries carry a fixed-width rd so the struct is usable for any NREG up to 2**HZ_RW_MAX.
package hazard_pkg;

    localparam int HZ_RW_MAX     = 8;
    localparam int FWD_RF        = 0;
    localparam int REG_ZERO      = 0;
    localparam int HZ_DEPTH      = 3;
    localparam int HZ_LOAD_STAGE = 2;
    localparam int HZ_CC_STAGE   = 2;

    typedef struct packed {
        logic                 v;
        logic [HZ_RW_MAX-1:0] rd;
        logic                 le;
        logic                 ld;
        logic                 cc;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hz_operand_match.sv
// Matches one ID source operand against the scoreboard: youngest producer index and load-use flag.
module hz_operand_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = HZ_DEPTH,
    parameter int LOAD_STAGE = HZ_LOAD_STAGE,
    parameter int RW         = 5,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic [RW-1:0]               op,
    input  logic                        op_use,
    input  sb_entry_t [DEPTH-1:0]       sb,
    output logic [FW-1:0]               fwd,
    output logic                        load_hit
);

    logic [DEPTH-1:0] hit;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = op_use && (op != RW'(REG_ZERO)) && sb[k].v && sb[k].le
                     && (sb[k].rd == HZ_RW_MAX'(op));
        end
    end

    // Walk oldest to youngest so the youngest match is the one left in fwd.
    always_comb begin
        fwd      = FW'(FWD_RF);
        load_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                fwd = FW'(k + 1);
                if (sb[k].ld && (k + 1 < LOAD_STAGE)) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboarded hazard unit beside ID: forwarding selects, load-use/CC stalls, annul flush, memory freeze.
// Optional HZ_PERF_EN adds saturating stall/wait/annul counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int RW         = $clog2(NREG),
    parameter int DEPTH      = HZ_DEPTH,
    parameter int LOAD_STAGE = HZ_LOAD_STAGE,
    parameter int CC_STAGE   = HZ_CC_STAGE,
    localparam int FW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_ra,
    input  logic [RW-1:0] id_rb,
    input  logic [RW-1:0] id_rs,
    input  logic          id_ra_use,
    input  logic          id_rb_use,
    input  logic          id_rs_use,
    input  logic [RW-1:0] id_rd,
    input  logic          id_rf_le,
    input  logic          id_load,
    input  logic          id_cc_we,
    input  logic          id_cc_use,
    input  logic          slot_annul,
    input  logic          mem_wait,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic          freeze,
    output logic          bubble_wb,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic [FW-1:0] fwd_s
`ifdef HZ_PERF_EN
    ,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_wait,
    output logic [31:0]   perf_annul
`endif
);

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;

    logic [2:0][RW-1:0] op_idx;
    logic [2:0]         op_use;
    logic [2:0][FW-1:0] op_fwd;
    logic [2:0]         op_lu;
    logic               cc_busy;
    logic               hazard;
    logic               issue;

    assign op_idx = {id_rs, id_rb, id_ra};
    assign op_use = {id_rs_use, id_rb_use, id_ra_use};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            hz_operand_match #(
                .DEPTH      (DEPTH),
                .LOAD_STAGE (LOAD_STAGE),
                .RW         (RW),
                .FW         (FW)
            ) u_match (
                .op       (op_idx[gi]),
                .op_use   (op_use[gi]),
                .sb       (sb_q),
                .fwd      (op_fwd[gi]),
                .load_hit (op_lu[gi])
            );
        end
    endgenerate

    always_comb begin
        cc_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k + 1 < CC_STAGE) && sb_q[k].v && sb_q[k].cc) begin
                cc_busy = 1'b1;
            end
        end
    end

    assign hazard = (|op_lu) || (id_valid && id_cc_use && cc_busy);

    // Priority: reset, then memory wait, then hazard stall, then annul.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        freeze    = 1'b0;
        bubble_wb = 1'b0;
        fwd_a     = FW'(FWD_RF);
        fwd_b     = FW'(FWD_RF);
        fwd_s     = FW'(FWD_RF);
        if (reset) begin
            fwd_a = op_fwd[0];
            fwd_b = op_fwd[1];
            fwd_s = op_fwd[2];
            if (mem_wait) begin
                freeze    = 1'b1;
                bubble_wb = 1'b1;
                stall_f   = 1'b1;
                stall_d   = 1'b1;
            end else if (hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (slot_annul && id_valid) begin
                flush_d = 1'b1;
            end
        end
    end

    assign issue = id_valid && !stall_d;

    always_comb begin
        sb_d = sb_q;
        if (mem_wait) begin
            sb_d[DEPTH-1] = SB_BUBBLE;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = SB_BUBBLE;
            if (issue) begin
                sb_d[0].v  = 1'b1;
                sb_d[0].rd = HZ_RW_MAX'(id_rd);
                sb_d[0].le = id_rf_le;
                sb_d[0].ld = id_load;
                sb_d[0].cc = id_cc_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HZ_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_wait_q,  perf_wait_d;
    logic [31:0] perf_annul_q, perf_annul_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_wait_d  = perf_wait_q;
        perf_annul_d = perf_annul_q;
        if (flush_e && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
        if (freeze  && (perf_wait_q  != 32'hFFFF_FFFF)) perf_wait_d  = perf_wait_q  + 32'd1;
        if (flush_d && (perf_annul_q != 32'hFFFF_FFFF)) perf_annul_d = perf_annul_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_wait_q  <= '0;
            perf_annul_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_wait_q  <= perf_wait_d;
            perf_annul_q <= perf_annul_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_wait  = perf_wait_q;
    assign perf_annul = perf_annul_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle behavioural scoreboard model.
module tb_pipe_hazard_ctrl;

    localparam int D  = 3;
    localparam int LS = 2;
    localparam int CS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_ra, id_rb, id_rs, id_rd;
    logic       id_ra_use, id_rb_use, id_rs_use;
    logic       id_rf_le, id_load, id_cc_we, id_cc_use;
    logic       slot_annul, mem_wait;
    logic       stall_f, stall_d, flush_d, flush_e, freeze, bubble_wb;
    logic [1:0] fwd_a, fwd_b, fwd_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_ra(id_ra), .id_rb(id_rb), .id_rs(id_rs),
        .id_ra_use(id_ra_use), .id_rb_use(id_rb_use), .id_rs_use(id_rs_use),
        .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
        .id_cc_we(id_cc_we), .id_cc_use(id_cc_use),
        .slot_annul(slot_annul), .mem_wait(mem_wait),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .freeze(freeze), .bubble_wb(bubble_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_s(fwd_s)
    );

    // Model: list of in-flight instructions, index 1 = EX ... D = WB.
    int m_v [1:D] = '{default: 0};
    int m_rd[1:D] = '{default: 0};
    int m_le[1:D] = '{default: 0};
    int m_ld[1:D] = '{default: 0};
    int m_cc[1:D] = '{default: 0};

    int e_stall_f, e_stall_d, e_flush_d, e_flush_e, e_freeze, e_bubble_wb;
    int e_fwd[3];

    task automatic cmp(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    function automatic void model_eval();
        int  opv[3];
        int  opu[3];
        int  f[3];
        bit  lu;
        bit  cch;
        opv = '{int'(id_ra), int'(id_rb), int'(id_rs)};
        opu = '{int'(id_ra_use), int'(id_rb_use), int'(id_rs_use)};
        lu  = 0;
        cch = 0;
        for (int i = 0; i < 3; i++) begin
            f[i] = 0;
            for (int k = 1; k <= D; k++) begin
                if (opu[i] != 0 && opv[i] != 0 && m_v[k] != 0 && m_le[k] != 0 && m_rd[k] == opv[i]) begin
                    if (f[i] == 0) f[i] = k;
                    if (m_ld[k] != 0 && k < LS) lu = 1;
                end
            end
        end
        for (int k = 1; k < CS && k <= D; k++)
            if (m_v[k] != 0 && m_cc[k] != 0) cch = id_valid && id_cc_use;
        e_stall_f = 0; e_stall_d = 0; e_flush_d = 0; e_flush_e = 0;
        e_freeze = 0; e_bubble_wb = 0; e_fwd = '{0, 0, 0};
        if (reset) begin
            e_fwd = f;
            if (mem_wait) begin
                e_freeze = 1; e_bubble_wb = 1; e_stall_f = 1; e_stall_d = 1;
            end else if (lu || cch) begin
                e_stall_f = 1; e_stall_d = 1; e_flush_e = 1;
            end else if (slot_annul && id_valid) begin
                e_flush_d = 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        model_eval();
        cmp("stall_f", int'(stall_f), e_stall_f);
        cmp("stall_d", int'(stall_d), e_stall_d);
        cmp("flush_d", int'(flush_d), e_flush_d);
        cmp("flush_e", int'(flush_e), e_flush_e);
        cmp("freeze", int'(freeze), e_freeze);
        cmp("bubble_wb", int'(bubble_wb), e_bubble_wb);
        cmp("fwd_a", int'(fwd_a), e_fwd[0]);
        cmp("fwd_b", int'(fwd_b), e_fwd[1]);
        cmp("fwd_s", int'(fwd_s), e_fwd[2]);
    end

    always @(posedge clk) begin
        model_eval();
        if (!reset) begin
            for (int k = 1; k <= D; k++) m_v[k] = 0;
        end else if (mem_wait) begin
            m_v[D] = 0;
        end else begin
            for (int k = D; k >= 2; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_le[k] = m_le[k-1];
                m_ld[k] = m_ld[k-1]; m_cc[k] = m_cc[k-1];
            end
            m_v[1]  = (id_valid && e_stall_d == 0) ? 1 : 0;
            m_rd[1] = int'(id_rd); m_le[1] = int'(id_rf_le);
            m_ld[1] = int'(id_load); m_cc[1] = int'(id_cc_we);
        end
    end

    task automatic set_id(input bit v, input int ra, input bit rau, input int rb, input bit rbu,
                          input int rs, input bit rsu, input int rd, input bit le, input bit ld,
                          input bit ccwe, input bit ccuse);
        id_valid = v;
        id_ra = 5'(ra); id_ra_use = rau;
        id_rb = 5'(rb); id_rb_use = rbu;
        id_rs = 5'(rs); id_rs_use = rsu;
        id_rd = 5'(rd); id_rf_le = le; id_load = ld;
        id_cc_we = ccwe; id_cc_use = ccuse;
    endtask

    task automatic at_check();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; mem_wait = 1'b1; slot_annul = 1'b1;
        set_id(1, 3, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        repeat (2) begin
            at_check();
            cmp("rst_freeze", int'(freeze), 0);
            cmp("rst_stall_d", int'(stall_d), 0);
            cmp("rst_flush_d", int'(flush_d), 0);
            next_cyc();
        end
        reset = 1'b1; mem_wait = 1'b0; slot_annul = 1'b0;

        // ADD r5 then readers of r5 as it ages through the pipe
        set_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        at_check(); cmp("add_issue_stall", int'(stall_d), 0); next_cyc();
        for (int n = 1; n <= 4; n++) begin
            set_id(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            at_check(); cmp("fwd_a_age", int'(fwd_a), (n <= 3) ? n : 0); next_cyc();
        end

        // LD r6 then read rb=6: one stall, then forward from stage 2
        set_id(1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        at_check(); next_cyc();
        set_id(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        at_check();
        cmp("lu_stall_f", int'(stall_f), 1);
        cmp("lu_flush_e", int'(flush_e), 1);
        cmp("lu_flush_d", int'(flush_d), 0);
        next_cyc();
        at_check();
        cmp("lu_clear", int'(stall_d), 0);
        cmp("lu_fwd_b", int'(fwd_b), 2);
        next_cyc();

        // SUBcc then BNE back to back, then with a NOP between
        set_id(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0); at_check(); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        at_check(); cmp("cc_stall", int'(stall_d), 1); next_cyc();
        at_check(); cmp("cc_clear", int'(stall_d), 0); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0); at_check(); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_check(); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        at_check(); cmp("cc_nop_nostall", int'(stall_d), 0); next_cyc();

        // LD r16 reaches MEM, then memory wait for 3 cycles
        set_id(1, 0, 0, 0, 0, 0, 0, 16, 1, 1, 0, 0); at_check(); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); at_check(); next_cyc();
        set_id(1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_wait = 1'b1;
        for (int n = 0; n < 3; n++) begin
            at_check();
            cmp("mw_freeze", int'(freeze), 1);
            cmp("mw_bubble_wb", int'(bubble_wb), 1);
            cmp("mw_flush_e", int'(flush_e), 0);
            cmp("mw_fwd_a", int'(fwd_a), 2);
            next_cyc();
        end
        mem_wait = 1'b0;
        at_check(); cmp("mw_rel_fwd2", int'(fwd_a), 2); cmp("mw_rel_freeze", int'(freeze), 0); next_cyc();
        at_check(); cmp("mw_rel_fwd3", int'(fwd_a), 3); next_cyc();
        at_check(); cmp("mw_rel_fwd0", int'(fwd_a), 0); next_cyc();

        // Annul without and with a concurrent load-use hazard
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); slot_annul = 1'b1;
        at_check(); cmp("annul_flush_d", int'(flush_d), 1); cmp("annul_stall_f", int'(stall_f), 0); next_cyc();
        slot_annul = 1'b0;
        at_check(); cmp("annul_once", int'(flush_d), 0); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0); at_check(); next_cyc();
        set_id(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); slot_annul = 1'b1;
        at_check(); cmp("annul_vs_lu_fd", int'(flush_d), 0); cmp("annul_vs_lu_sd", int'(stall_d), 1); next_cyc();
        at_check(); cmp("annul_after_lu", int'(flush_d), 1); next_cyc();
        slot_annul = 1'b0;

        // r0 never hazards; duplicate rd resolves to youngest
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); at_check(); next_cyc();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        at_check(); cmp("r0_fwd_a", int'(fwd_a), 0); cmp("r0_stall", int'(stall_d), 0); next_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0, 0); at_check(); next_cyc();
        at_check(); next_cyc();
        set_id(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0);
        at_check(); cmp("dup_fwd_s", int'(fwd_s), 1); next_cyc();

        // Reset asserted in the middle of a load-use stall
        set_id(1, 0, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0); at_check(); next_cyc();
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        at_check(); cmp("pre_rst_stall", int'(stall_d), 1);
        reset = 1'b0; mem_wait = 1'b1;
        #1;
        cmp("midrst_stall_d", int'(stall_d), 0);
        cmp("midrst_freeze", int'(freeze), 0);
        cmp("midrst_fwd_a", int'(fwd_a), 0);
        next_cyc();
        reset = 1'b1; mem_wait = 1'b0;
        at_check(); cmp("postrst_fwd_a", int'(fwd_a), 0); cmp("postrst_stall", int'(stall_d), 0); next_cyc();

        // Mixed tail: small register range so hazards are frequent
        for (int n = 0; n < 300; n++) begin
            set_id($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            slot_annul = ($urandom_range(0, 3) == 0);
            mem_wait   = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 40) != 0);
            at_check();
            next_cyc();
        end

        reset = 1'b1; mem_wait = 1'b0; slot_annul = 1'b0;
        at_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
